control_unit: RTL and testbench
===============================

# control_unit

Control unit `cu` for the 4-bit-address, 8-bit-data teaching microprocessor. It fetches instructions from an external 16-byte program/data memory through `PC`/`INSTRUCTION`, and sequences each instruction through a fixed fetch/decode/execute FSM. It owns the accumulator A, an 8×8 register file, the ALU and the shifter. Every datapath control strobe is exported for observation and for the external memory's write port.

## Interface
- Parameters: none.
- `clk_ctrl` in 1 — single clock, rising-edge active.
- `rst_ctrl` in 1 — reset, asynchronous, active-low.
- `INSTRUCTION` in 8 — memory read data; must equal mem[`PC`] and be valid before the next rising edge.
- `input_ctrl` in 8 — external input port (IN instruction).
- `zero_ctrl` in 1 — condition input for JZ.
- `positive_ctrl` in 1 — condition input for JP.
- `PC` out 4 — program counter / memory read address.
- `muxsel_ctrl` out 2 — A-input select: 00 ALU/shifter, 01 imm, 10 register file, 11 `input_ctrl`.
- `imm_ctrl` out 8 — latched immediate byte.
- `accwr_ctrl` out 1 — A write enable.
- `rfaddr_ctrl` out 3 — register-file address.
- `rfwr_ctrl` out 1 — register-file write enable.
- `mmadr_ctrl` out 4 — data-memory write address.
- `mmwr_ctrl` out 1 — memory write strobe; data is `output_ctrl`.
- `alusel_ctrl` out 3 — 000 pass A, 001 AND, 010 OR, 011 NOT A, 100 ADD, 101 SUB, 110 INC, 111 DEC.
- `shiftsel_ctrl` out 2 — 00 pass, 01 shift left, 10 shift right (0 fill), 11 rotate right.
- `outen_ctrl` out 1 — output enable.
- `output_ctrl` out 8 — equals A while `outen_ctrl` or `mmwr_ctrl` is 1, else 8'h00.

## Operation
- Opcode is IR[7:4]. r = IR[2:0]. n = IR[3:0]. All arithmetic is 8-bit modulo 256. A = A op R[r] unless noted.
- 0000 NOP.
- 0001 LDA r: A←R[r], mux 10.
- 0010 STA r: R[r]←A.
- 0011 STM n: mem[n]←A.
- 0100 JMP n: PC←n.
- 0101 LDI: two-byte instruction. A←next byte, mux 01; PC advances by 2 in total.
- 0110 ADD r. 0111 SUB r. 1000 AND r. 1001 OR r.
- 1010 JZ n: PC←n if `zero_ctrl`=1.
- 1011 JP n: PC←n if `positive_ctrl`=1.
- 1100 SHF: A←shift(A) with shiftsel=IR[1:0], alusel 000.
- 1101 NOT: A←~A.
- 1110 IN: A←`input_ctrl`, mux 11.
- 1111 OUT: `outen_ctrl`=1 for one cycle.
- FSM states:
  - FETCH: IR←`INSTRUCTION`, PC←PC+1, go to DECODE.
  - DECODE: for LDI, imm←`INSTRUCTION` and PC←PC+1; otherwise no state change. Go to EXECUTE.
  - EXECUTE: A, R or PC update on the edge leaving this state, then go to FETCH.
- Strobes are decoded combinationally from state and IR:
  - `accwr`, `rfwr`, `mmwr`, `outen` are 1 only in EXECUTE of the relevant opcode.
  - `rfaddr_ctrl`=r and `mmadr_ctrl`=n in DECODE and EXECUTE.
  - All strobes and selects are 0 in FETCH.
- `imm_ctrl` holds its value until the next LDI.
- A jump in EXECUTE overrides the PC+1 already applied.
- PC wraps 15→0. An LDI at address 15 takes its immediate from address 0.

## Timing
- Every instruction takes exactly 3 cycles, LDI included.
- Results are visible in A or R the cycle after EXECUTE.
- `PC` is a register. Memory has up to one clock period to return `INSTRUCTION`.
- On asynchronous reset (rst_ctrl=0): PC=0, state=FETCH, IR=0, A=0, all R=0, imm=0, all strobes 0, `output_ctrl`=0.
- Reset asserted mid-instruction aborts it with no write. Fetch restarts at address 0 on the first rising edge after release.
- Condition inputs are sampled on the EXECUTE edge only.

## Test plan
- Reset, then program LDI A,0x0D; STA R1 → after 6 cycles R1=0x0D. `rfwr_ctrl` pulses once with `rfaddr_ctrl`=1. PC=3.
- LDI A,0x05; STA R2; LDI A,0x03; ADD R2 → A=0x08. SUB R2 from A=0x03 → A=0xFE.
- `input_ctrl`=0x3D, IN then OUT → `outen_ctrl` is high for one cycle with `output_ctrl`=0x3D, and 0x00 otherwise.
- A=0x81: SHF 01→0x02, SHF 10→0x40, SHF 11 on 0x81→0xC0.
- JZ 0x9 with `zero_ctrl`=0 → PC=next sequential address. With `zero_ctrl`=1 → PC=9. JMP 0x0 at address 15 → PC=0.
- STM 0x7 with A=0x2A → `mmwr_ctrl`=1, `mmadr_ctrl`=7, `output_ctrl`=0x2A for one cycle. Reset pulse during that EXECUTE → no strobe, PC=0.

Source files
------------

// File: rtl/control_unit.sv
// Control unit for the 4-bit-address, 8-bit-data teaching processor: fetch/decode/execute
// sequencer owning the accumulator, an 8x8 register file, the ALU and the shifter.
module control_unit (
  input  logic       clk_ctrl,
  input  logic       rst_ctrl,
  input  logic [7:0] INSTRUCTION,
  input  logic [7:0] input_ctrl,
  input  logic       zero_ctrl,
  input  logic       positive_ctrl,
  output logic [3:0] PC,
  output logic [1:0] muxsel_ctrl,
  output logic [7:0] imm_ctrl,
  output logic       accwr_ctrl,
  output logic [2:0] rfaddr_ctrl,
  output logic       rfwr_ctrl,
  output logic [3:0] mmadr_ctrl,
  output logic       mmwr_ctrl,
  output logic [2:0] alusel_ctrl,
  output logic [1:0] shiftsel_ctrl,
  output logic       outen_ctrl,
  output logic [7:0] output_ctrl
);

  localparam logic [1:0] StFetch  = 2'd0;
  localparam logic [1:0] StDecode = 2'd1;
  localparam logic [1:0] StExec   = 2'd2;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpSta = 4'h2;
  localparam logic [3:0] OpStm = 4'h3;
  localparam logic [3:0] OpJmp = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpAdd = 4'h6;
  localparam logic [3:0] OpSub = 4'h7;
  localparam logic [3:0] OpAnd = 4'h8;
  localparam logic [3:0] OpOr  = 4'h9;
  localparam logic [3:0] OpJz  = 4'hA;
  localparam logic [3:0] OpJp  = 4'hB;
  localparam logic [3:0] OpShf = 4'hC;
  localparam logic [3:0] OpNot = 4'hD;
  localparam logic [3:0] OpIn  = 4'hE;
  localparam logic [3:0] OpOut = 4'hF;

  logic [1:0] state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] imm_q, imm_d;
  logic [7:0] rf_q [8];

  logic [3:0] opcode;
  logic       active, in_exec;
  logic [7:0] rf_rd, alu_res, shift_res, acc_in;

  assign opcode  = ir_q[7:4];
  assign active  = (state_q != StFetch);
  assign in_exec = (state_q == StExec);
  assign rf_rd   = rf_q[ir_q[2:0]];

  // Selects are driven through DECODE and EXECUTE; write strobes only in EXECUTE.
  always_comb begin
    muxsel_ctrl   = 2'b00;
    alusel_ctrl   = 3'b000;
    shiftsel_ctrl = 2'b00;
    rfaddr_ctrl   = 3'd0;
    mmadr_ctrl    = 4'd0;
    accwr_ctrl    = 1'b0;
    rfwr_ctrl     = 1'b0;
    mmwr_ctrl     = 1'b0;
    outen_ctrl    = 1'b0;
    if (active) begin
      rfaddr_ctrl = ir_q[2:0];
      mmadr_ctrl  = ir_q[3:0];
      case (opcode)
        OpLda: muxsel_ctrl = 2'b10;
        OpLdi: muxsel_ctrl = 2'b01;
        OpIn:  muxsel_ctrl = 2'b11;
        OpAdd: alusel_ctrl = 3'b100;
        OpSub: alusel_ctrl = 3'b101;
        OpAnd: alusel_ctrl = 3'b001;
        OpOr:  alusel_ctrl = 3'b010;
        OpNot: alusel_ctrl = 3'b011;
        OpShf: shiftsel_ctrl = ir_q[1:0];
        default: ;
      endcase
    end
    if (in_exec) begin
      case (opcode)
        OpLda, OpLdi, OpAdd, OpSub, OpAnd, OpOr, OpShf, OpNot, OpIn: accwr_ctrl = 1'b1;
        OpSta: rfwr_ctrl  = 1'b1;
        OpStm: mmwr_ctrl  = 1'b1;
        OpOut: outen_ctrl = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case (alusel_ctrl)
      3'b001:  alu_res = acc_q & rf_rd;
      3'b010:  alu_res = acc_q | rf_rd;
      3'b011:  alu_res = ~acc_q;
      3'b100:  alu_res = acc_q + rf_rd;
      3'b101:  alu_res = acc_q - rf_rd;
      3'b110:  alu_res = acc_q + 8'd1;
      3'b111:  alu_res = acc_q - 8'd1;
      default: alu_res = acc_q;
    endcase
    case (shiftsel_ctrl)
      2'b01:   shift_res = {alu_res[6:0], 1'b0};
      2'b10:   shift_res = {1'b0, alu_res[7:1]};
      2'b11:   shift_res = {alu_res[0], alu_res[7:1]};
      default: shift_res = alu_res;
    endcase
    case (muxsel_ctrl)
      2'b01:   acc_in = imm_q;
      2'b10:   acc_in = rf_rd;
      2'b11:   acc_in = input_ctrl;
      default: acc_in = shift_res;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    imm_d   = imm_q;
    case (state_q)
      StFetch: begin
        ir_d    = INSTRUCTION;
        pc_d    = pc_q + 4'd1;
        state_d = StDecode;
      end
      StDecode: begin
        if (opcode == OpLdi) begin
          imm_d = INSTRUCTION;
          pc_d  = pc_q + 4'd1;
        end
        state_d = StExec;
      end
      StExec: begin
        if (accwr_ctrl) acc_d = acc_in;
        // Taken jump replaces the increment already applied during fetch.
        if ((opcode == OpJmp) || ((opcode == OpJz) && zero_ctrl) ||
            ((opcode == OpJp) && positive_ctrl)) begin
          pc_d = ir_q[3:0];
        end
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk_ctrl or negedge rst_ctrl) begin
    if (!rst_ctrl) begin
      state_q <= StFetch;
      pc_q    <= 4'd0;
      ir_q    <= 8'd0;
      acc_q   <= 8'd0;
      imm_q   <= 8'd0;
      for (int i = 0; i < 8; i++) rf_q[i] <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      imm_q   <= imm_d;
      if (rfwr_ctrl) rf_q[ir_q[2:0]] <= acc_q;
    end
  end

  assign PC          = pc_q;
  assign imm_ctrl    = imm_q;
  assign output_ctrl = (outen_ctrl || mmwr_ctrl) ? acc_q : 8'h00;

  logic unused_nop;
  assign unused_nop = (opcode == OpNop);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: small programs in a behavioural 16-byte memory, results
// observed through the OUT/STM strobes and the PC.
module tb_control_unit;

  logic       clk_ctrl = 1'b0;
  logic       rst_ctrl = 1'b0;
  logic [7:0] INSTRUCTION;
  logic [7:0] input_ctrl = 8'h00;
  logic       zero_ctrl = 1'b0;
  logic       positive_ctrl = 1'b0;
  logic [3:0] PC;
  logic [1:0] muxsel_ctrl;
  logic [7:0] imm_ctrl;
  logic       accwr_ctrl;
  logic [2:0] rfaddr_ctrl;
  logic       rfwr_ctrl;
  logic [3:0] mmadr_ctrl;
  logic       mmwr_ctrl;
  logic [2:0] alusel_ctrl;
  logic [1:0] shiftsel_ctrl;
  logic       outen_ctrl;
  logic [7:0] output_ctrl;

  control_unit dut (
    .clk_ctrl      (clk_ctrl),
    .rst_ctrl      (rst_ctrl),
    .INSTRUCTION   (INSTRUCTION),
    .input_ctrl    (input_ctrl),
    .zero_ctrl     (zero_ctrl),
    .positive_ctrl (positive_ctrl),
    .PC            (PC),
    .muxsel_ctrl   (muxsel_ctrl),
    .imm_ctrl      (imm_ctrl),
    .accwr_ctrl    (accwr_ctrl),
    .rfaddr_ctrl   (rfaddr_ctrl),
    .rfwr_ctrl     (rfwr_ctrl),
    .mmadr_ctrl    (mmadr_ctrl),
    .mmwr_ctrl     (mmwr_ctrl),
    .alusel_ctrl   (alusel_ctrl),
    .shiftsel_ctrl (shiftsel_ctrl),
    .outen_ctrl    (outen_ctrl),
    .output_ctrl   (output_ctrl)
  );

  always #5 clk_ctrl = ~clk_ctrl;

  logic [7:0] mem [16];
  assign INSTRUCTION = mem[PC];

  logic [17:0] strobes;
  assign strobes = {muxsel_ctrl, accwr_ctrl, rfaddr_ctrl, rfwr_ctrl, mmadr_ctrl, mmwr_ctrl,
                    alusel_ctrl, shiftsel_ctrl, outen_ctrl};

  int         out_cnt = 0;
  int         rf_cnt = 0;
  int         mm_cnt = 0;
  logic [7:0] last_out = 8'h00;
  logic [2:0] last_rfaddr = 3'd0;

  always @(negedge clk_ctrl) begin
    if (rst_ctrl) begin
      if (outen_ctrl) begin
        out_cnt  <= out_cnt + 1;
        last_out <= output_ctrl;
      end
      if (rfwr_ctrl) begin
        rf_cnt      <= rf_cnt + 1;
        last_rfaddr <= rfaddr_ctrl;
      end
      if (mmwr_ctrl) mm_cnt <= mm_cnt + 1;
    end
  end

  typedef struct {
    string        name;
    logic [127:0] prog;   // byte 0 in the top bits
    logic [7:0]   in_val;
    logic         zf;
    logic         pf;
    int           n_instr;
    logic [7:0]   exp_out;
    int           exp_outs;
    logic [3:0]   exp_pc;
  } vec_t;

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic [127:0] p, input logic [7:0] iv,
                              input logic z, input logic ps, input int n, input logic [7:0] eo,
                              input int eos, input logic [3:0] epc);
    vec_t v;
    v.name = nm; v.prog = p; v.in_val = iv; v.zf = z; v.pf = ps;
    v.n_instr = n; v.exp_out = eo; v.exp_outs = eos; v.exp_pc = epc;
    return v;
  endfunction

  task automatic load(input logic [127:0] p);
    for (int i = 0; i < 16; i++) mem[i] = p[127-8*i -: 8];
  endtask

  task automatic do_reset();
    @(negedge clk_ctrl);
    rst_ctrl = 1'b0;
    @(negedge clk_ctrl);
    rst_ctrl = 1'b1;
  endtask

  vec_t vecs [16];
  int   b_out, b_rf, b_mm;

  initial begin
    vecs[0]  = mk("lda_sta", {56'h500D21500011F0, 72'h0}, 8'h00, 1'b0, 1'b0, 5, 8'h0D, 1, 4'd7);
    vecs[1]  = mk("add",     {56'h500522500362F0, 72'h0}, 8'h00, 1'b0, 1'b0, 5, 8'h08, 1, 4'd7);
    vecs[2]  = mk("sub",     {56'h500522500372F0, 72'h0}, 8'h00, 1'b0, 1'b0, 5, 8'hFE, 1, 4'd7);
    vecs[3]  = mk("nop_in",  {24'h00E0F0, 104'h0},        8'h3D, 1'b0, 1'b0, 3, 8'h3D, 1, 4'd3);
    vecs[4]  = mk("shl",     {32'h5081C1F0, 96'h0},       8'h00, 1'b0, 1'b0, 3, 8'h02, 1, 4'd4);
    vecs[5]  = mk("shr",     {32'h5081C2F0, 96'h0},       8'h00, 1'b0, 1'b0, 3, 8'h40, 1, 4'd4);
    vecs[6]  = mk("ror",     {32'h5081C3F0, 96'h0},       8'h00, 1'b0, 1'b0, 3, 8'hC0, 1, 4'd4);
    vecs[7]  = mk("and",     {56'h503C2350F083F0, 72'h0}, 8'h00, 1'b0, 1'b0, 5, 8'h30, 1, 4'd7);
    vecs[8]  = mk("or",      {56'h503C2350C393F0, 72'h0}, 8'h00, 1'b0, 1'b0, 5, 8'hFF, 1, 4'd7);
    vecs[9]  = mk("not",     {32'h505AD0F0, 96'h0},       8'h00, 1'b0, 1'b0, 3, 8'hA5, 1, 4'd4);
    vecs[10] = mk("jz_nt", {32'hA95011F0, 40'h0, 24'h5022F0, 32'h0}, 8'h00, 1'b0, 1'b1, 3,
                  8'h11, 1, 4'd4);
    vecs[11] = mk("jz_t",  {32'hA95011F0, 40'h0, 24'h5022F0, 32'h0}, 8'h00, 1'b1, 1'b0, 3,
                  8'h22, 1, 4'd12);
    vecs[12] = mk("jp_t",  {32'hB95011F0, 40'h0, 24'h5022F0, 32'h0}, 8'h00, 1'b0, 1'b1, 3,
                  8'h22, 1, 4'd12);
    vecs[13] = mk("jp_nt", {32'hB95011F0, 40'h0, 24'h5022F0, 32'h0}, 8'h00, 1'b1, 1'b0, 3,
                  8'h11, 1, 4'd4);
    vecs[14] = mk("jmp_wrap", {32'hF050994F, 88'h0, 8'h40}, 8'h00, 1'b0, 1'b0, 5, 8'h99, 2, 4'd1);
    vecs[15] = mk("ldi_wrap", {16'h4FF0, 104'h0, 8'h50},    8'h00, 1'b0, 1'b0, 3, 8'h4F, 1, 4'd2);

    // Reset state.
    load(128'h0);
    repeat (2) @(negedge clk_ctrl);
    #1;
    chk("reset_pc", 32'(PC), 32'd0);
    chk("reset_strobes", 32'(strobes), 32'd0);
    chk("reset_out", 32'(output_ctrl), 32'd0);
    chk("reset_imm", 32'(imm_ctrl), 32'd0);

    // LDI 0x0D; STA R1.
    load({24'h500D21, 104'h0});
    do_reset();
    b_rf = rf_cnt;
    repeat (3) @(negedge clk_ctrl);
    #1;
    chk("fetch_strobes", 32'(strobes), 32'd0);
    chk("ldi_imm", 32'(imm_ctrl), 32'h0D);
    repeat (3) @(negedge clk_ctrl);
    #1;
    chk("sta_pc", 32'(PC), 32'd3);
    chk("sta_rfwr_pulses", 32'(rf_cnt - b_rf), 32'd1);
    chk("sta_rfaddr", 32'(last_rfaddr), 32'd1);

    // LDI 0x2A; STM 7.
    load({24'h502A37, 104'h0});
    do_reset();
    b_mm = mm_cnt;
    repeat (5) @(negedge clk_ctrl);
    #1;
    chk("stm_mmwr", 32'(mmwr_ctrl), 32'd1);
    chk("stm_mmadr", 32'(mmadr_ctrl), 32'd7);
    chk("stm_out", 32'(output_ctrl), 32'h2A);
    @(negedge clk_ctrl);
    #1;
    chk("stm_mmwr_off", 32'(mmwr_ctrl), 32'd0);
    chk("stm_out_off", 32'(output_ctrl), 32'd0);
    chk("stm_pulses", 32'(mm_cnt - b_mm), 32'd1);
    chk("stm_pc", 32'(PC), 32'd3);

    // Same program, reset pulsed in the middle of the STM execute cycle.
    do_reset();
    b_mm = mm_cnt;
    repeat (4) @(negedge clk_ctrl);
    @(posedge clk_ctrl);
    #2;
    rst_ctrl = 1'b0;
    #1;
    chk("abort_mmwr", 32'(mmwr_ctrl), 32'd0);
    chk("abort_out", 32'(output_ctrl), 32'd0);
    chk("abort_pc", 32'(PC), 32'd0);
    @(negedge clk_ctrl);
    rst_ctrl = 1'b1;
    @(negedge clk_ctrl);
    #1;
    chk("abort_restart_pc", 32'(PC), 32'd1);
    chk("abort_no_write", 32'(mm_cnt - b_mm), 32'd0);

    for (int i = 0; i < 16; i++) begin
      input_ctrl    = vecs[i].in_val;
      zero_ctrl     = vecs[i].zf;
      positive_ctrl = vecs[i].pf;
      load(vecs[i].prog);
      do_reset();
      b_out = out_cnt;
      repeat (3 * vecs[i].n_instr) @(negedge clk_ctrl);
      #1;
      chk({vecs[i].name, "_out"}, 32'(last_out), 32'(vecs[i].exp_out));
      chk({vecs[i].name, "_outen_pulses"}, 32'(out_cnt - b_out), 32'(vecs[i].exp_outs));
      chk({vecs[i].name, "_pc"}, 32'(PC), 32'(vecs[i].exp_pc));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
